dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit memory words (power of two).
REQ-002 SHALL have derived constant ADDR_W = log2(DEPTH_WORDS), meaning the word-index width.
REQ-003 SHALL have clock: clk  input  1  single clock; all logic samples on its rising edge.
REQ-004 SHALL have reset: rst  input  1  reset, synchronous and active-low.
REQ-005 SHALL have dmemAddr  input  32  byte address of the request.
REQ-006 SHALL have dmemWdata  input  32  store data, LSB-aligned.
REQ-007 SHALL have dmemSize  input  3  access size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have dmemWen  input  1  store request this cycle.
REQ-009 SHALL have dmemRen  input  1  load request this cycle.
REQ-010 SHALL have dmemRdata  output  32  extended load result.
REQ-011 SHALL have dmemErr  output  1  fault flag, aligned with the result cycle.
REQ-012 SHALL have dmemReady  output  1  high once memory initialisation is complete.

Function
REQ-013 SHALL implement FSM states INIT and READY; reset enters INIT.
REQ-014 In INIT, SHALL clear one word per cycle, indices 0..DEPTH_WORDS-1, then go to READY; dmemReady is low in INIT and high in READY.
REQ-015 In INIT, SHALL ignore dmemWen/dmemRen: no memory update, dmemErr stays 0, dmemRdata is unchanged.
REQ-016 Word index SHALL be dmemAddr[ADDR_W+1:2]; a nonzero dmemAddr[31:ADDR_W+2] is an out-of-range fault.
REQ-017 Misalignment SHALL be: H/HU with addr[0]=1, W with addr[1:0]!=0; any other size code is also a fault.
REQ-018 Stores SHALL complete at the request edge; SB writes wdata[7:0] to lane addr[1:0], SH writes wdata[15:0] to lanes {addr[1],0}/{addr[1],1}, SW writes all four lanes.
REQ-019 Load latency SHALL be exactly one cycle: a request at edge N gives dmemRdata/dmemErr valid after edge N+1.
REQ-020 Load result SHALL be: word shifted right by 8*addr[1:0], then sign-extended (B/H) or zero-extended (BU/HU); W is unmodified.
REQ-021 dmemRdata SHALL hold its last value in cycles with no load.
REQ-022 dmemErr SHALL be a one-cycle pulse in the cycle after any faulting request (load or store).
REQ-023 A faulting store SHALL leave memory unchanged; a faulting load SHALL return 0.
REQ-024 dmemWen and dmemRen together SHALL be treated as a fault: no write, read data 0, dmemErr pulse.
REQ-025 A load in the cycle after a store to the same word SHALL return the newly stored data.
REQ-026 A store in the cycle after a load to the same word SHALL NOT affect that load's result.

Reset
REQ-027 While rst=0: dmemRdata=0, dmemErr=0, dmemReady=0, FSM=INIT, init counter=0.
REQ-028 Reset asserted mid-INIT or mid-READY SHALL restart initialisation from index 0; any outstanding load result is discarded.
REQ-029 Memory contents SHALL NOT be reset directly; they are cleared only by INIT.

Structure
REQ-030 Size codes (LS_B, LS_H, LS_W, LS_BU, LS_HU) and the FSM state enum SHALL live in shared package dmem_pkg.
REQ-031 Storage SHALL be a sub-module dmem_bank: four 8-bit lanes of DEPTH_WORDS entries, with per-lane write enables and a registered 32-bit read port.
REQ-032 Alignment, fault, lane-enable and extension logic SHALL reside in dmem_responder.

Verification
REQ-033 Reset, then hold idle: dmemReady rises exactly DEPTH_WORDS cycles after rst goes high; a LW of every tested word returns 0x00000000.
REQ-034 SW 0x80FF7F01 @0x10, then LB/LBU @0x13 -> 0xFFFFFF80/0x00000080, LH @0x12 -> 0xFFFF80FF, LHU @0x10 -> 0x00007F01.
REQ-035 SB 0xAA @0x21, SH 0xBEEF @0x22 over word 0x11223344 -> LW @0x20 -> 0xBEEFAA44.
REQ-036 LW @0x02, SH @0x01, and LB @(DEPTH_WORDS*4) -> dmemErr pulse each time, memory unchanged, loads return 0.
REQ-037 Back-to-back SW 0x12345678 @0x40 then LW @0x40 -> 0x12345678; LW @0x44 then SW @0x44 -> old value.
REQ-038 Reset asserted at init index 5 during INIT -> counter restarts at 0, dmemReady is delayed a full DEPTH_WORDS cycles, no dmemErr.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access size codes,
// FSM state type and the small combinational helpers for alignment,
// lane selection and load extension.
package dmem_pkg;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } dmem_state_e;

    // Unknown size codes and misaligned halfword/word accesses are faults.
    function automatic logic access_fault(input logic [2:0] size, input logic [1:0] off);
        logic f;
        case (size)
            LS_B, LS_BU: f = 1'b0;
            LS_H, LS_HU: f = off[0];
            LS_W:        f = (off != 2'b00);
            default:     f = 1'b1;
        endcase
        return f;
    endfunction

    // Byte lanes touched by a store of the given size at the given offset.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] off);
        logic [3:0] m;
        case (size)
            LS_B, LS_BU: m = 4'b0001 << off;
            LS_H, LS_HU: m = off[1] ? 4'b1100 : 4'b0011;
            LS_W:        m = 4'b1111;
            default:     m = 4'b0000;
        endcase
        return m;
    endfunction

    // Replicate LSB-aligned store data so every candidate lane sees it.
    function automatic logic [31:0] store_align(input logic [2:0] size, input logic [31:0] data);
        logic [31:0] d;
        case (size)
            LS_B, LS_BU: d = {4{data[7:0]}};
            LS_H, LS_HU: d = {2{data[15:0]}};
            default:     d = data;
        endcase
        return d;
    endfunction

    // Shift the addressed bytes down and sign/zero extend by size code.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] size,
                                                input logic [1:0] off);
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> {off, 3'b000};
        case (size)
            LS_B:    r = {{24{sh[7]}}, sh[7:0]};
            LS_BU:   r = {24'h000000, sh[7:0]};
            LS_H:    r = {{16{sh[15]}}, sh[15:0]};
            LS_HU:   r = {16'h0000, sh[15:0]};
            LS_W:    r = sh;
            default: r = 32'h00000000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Data-memory request/response bundle. The master drives requests, the
// slave (dmem_responder) returns load data, fault and ready status.
interface dmem_if;
    logic [31:0] dmemAddr;
    logic [31:0] dmemWdata;
    logic [2:0]  dmemSize;
    logic        dmemWen;
    logic        dmemRen;
    logic [31:0] dmemRdata;
    logic        dmemErr;
    logic        dmemReady;

    modport master (
        output dmemAddr, dmemWdata, dmemSize, dmemWen, dmemRen,
        input  dmemRdata, dmemErr, dmemReady
    );

    modport slave (
        input  dmemAddr, dmemWdata, dmemSize, dmemWen, dmemRen,
        output dmemRdata, dmemErr, dmemReady
    );
endinterface

// File: rtl/dmem_bank.sv
// Four byte-wide storage lanes with per-lane write enables and a registered
// 32-bit read port. Contents are never reset; the owner clears them.
module dmem_bank #(
    parameter  int DEPTH_WORDS = 1024,
    localparam int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] mem_r [DEPTH_WORDS];
        logic [7:0] rd_r;

        // Lane write: one byte per enabled lane at the write index.
        always_ff @(posedge clk) begin
            if (we[l]) begin
                mem_r[waddr] <= wdata[8*l +: 8];
            end
        end

        // Lane read: capture only on a read so the result holds otherwise.
        always_ff @(posedge clk) begin
            if (re) begin
                rd_r <= mem_r[raddr];
            end
        end

        assign rdata[8*l +: 8] = rd_r;
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: clears storage after reset, then serves byte,
// halfword and word loads/stores with one-cycle load latency and a
// one-cycle fault pulse for bad requests.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);
    import dmem_pkg::*;

    localparam int                ADDR_W   = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH_WORDS - 1);

    dmem_state_e       state_r;
    logic [ADDR_W-1:0] init_idx_r;
    logic              ready_r;
    logic              err_r;
    logic              ld_zero_r;
    logic [2:0]        ld_size_r;
    logic [1:0]        ld_off_r;

    logic [ADDR_W-1:0] word_idx_s;
    logic [1:0]        byte_off_s;
    logic              out_of_range_s;
    logic              fault_s;
    logic              req_s;
    logic              accept_s;
    logic [3:0]        bank_we_s;
    logic [ADDR_W-1:0] bank_waddr_s;
    logic [31:0]       bank_wdata_s;
    logic              bank_re_s;
    logic [31:0]       bank_rdata_s;

    assign byte_off_s     = bus.dmemAddr[1:0];
    assign word_idx_s     = bus.dmemAddr[ADDR_W+1:2];
    assign out_of_range_s = (bus.dmemAddr >> (ADDR_W + 2)) != 32'd0;
    assign req_s          = bus.dmemWen | bus.dmemRen;
    // Simultaneous load and store is rejected as a whole.
    assign fault_s        = out_of_range_s | access_fault(bus.dmemSize, byte_off_s)
                          | (bus.dmemWen & bus.dmemRen);
    assign accept_s       = (state_r == ST_READY);
    assign bank_re_s      = accept_s & bus.dmemRen & ~fault_s;

    // Bank write port: clearing sweep during INIT, accepted stores otherwise.
    always_comb begin
        bank_we_s    = 4'b0000;
        bank_waddr_s = word_idx_s;
        bank_wdata_s = bus.dmemWdata;
        if (state_r == ST_INIT) begin
            bank_we_s    = 4'b1111;
            bank_waddr_s = init_idx_r;
            bank_wdata_s = 32'h00000000;
        end else if (bus.dmemWen && !fault_s) begin
            bank_we_s    = lane_mask(bus.dmemSize, byte_off_s);
            bank_waddr_s = word_idx_s;
            bank_wdata_s = store_align(bus.dmemSize, bus.dmemWdata);
        end else begin
            bank_we_s    = 4'b0000;
        end
    end

    dmem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_bank (
        .clk   (clk),
        .we    (bank_we_s),
        .waddr (bank_waddr_s),
        .wdata (bank_wdata_s),
        .re    (bank_re_s),
        .raddr (word_idx_s),
        .rdata (bank_rdata_s)
    );

    // Control FSM, init sweep counter, fault pulse and pending-load context.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_INIT;
            init_idx_r <= '0;
            ready_r    <= 1'b0;
            err_r      <= 1'b0;
            ld_zero_r  <= 1'b1;
            ld_size_r  <= LS_W;
            ld_off_r   <= 2'b00;
        end else begin
            case (state_r)
                ST_INIT: begin
                    err_r      <= 1'b0;
                    init_idx_r <= init_idx_r + ADDR_W'(1);
                    if (init_idx_r == LAST_IDX) begin
                        state_r <= ST_READY;
                        ready_r <= 1'b1;
                    end
                end
                ST_READY: begin
                    err_r <= req_s & fault_s;
                    if (bus.dmemRen) begin
                        // A faulting load forces the visible result to zero.
                        ld_zero_r <= fault_s;
                        ld_size_r <= bus.dmemSize;
                        ld_off_r  <= byte_off_s;
                    end
                end
                default: begin
                    state_r    <= ST_INIT;
                    init_idx_r <= '0;
                    ready_r    <= 1'b0;
                    err_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dmemRdata = ld_zero_r ? 32'h00000000
                                     : load_extend(bank_rdata_s, ld_size_r, ld_off_r);
    assign bus.dmemErr   = err_r;
    assign bus.dmemReady = ready_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios against fixed
// expected values plus randomized traffic against a byte-level memory model.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DEPTH = 1024;

    logic clk;
    logic rst;
    dmem_if bus ();

    dmem_responder #(.DEPTH_WORDS(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_rdata;
    logic        model_ready;

    function automatic int unsigned size_bytes(input logic [2:0] sz);
        case (sz)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic mdl_fault(input logic wen, input logic ren, input logic [31:0] addr,
                                       input logic [2:0] sz);
        int unsigned n;
        n = size_bytes(sz);
        if (n == 0) return 1'b1;
        if ((addr % n) != 0) return 1'b1;
        if ((addr / 4) >= DEPTH) return 1'b1;
        if (wen && ren) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] mdl_load(input logic [31:0] word, input logic [31:0] addr,
                                             input logic [2:0] sz);
        logic [31:0] v;
        logic [31:0] b;
        logic [31:0] h;
        v = word >> (8 * (addr % 4));
        b = v & 32'h000000FF;
        h = v & 32'h0000FFFF;
        case (sz)
            3'd0:    return (b >= 32'h80)   ? b - 32'h100   : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'h8000) ? h - 32'h10000 : h;
            3'd5:    return h;
            3'd2:    return v;
            default: return 32'h0;
        endcase
    endfunction

    // Drive one request cycle, advance the model, return expected outputs.
    task automatic issue(input logic wen, input logic ren, input logic [31:0] addr,
                         input logic [2:0] sz, input logic [31:0] wd,
                         output logic [31:0] exp_d, output logic exp_e);
        logic        f;
        logic [31:0] w;
        int unsigned n;
        bus.dmemWen   = wen;
        bus.dmemRen   = ren;
        bus.dmemAddr  = addr;
        bus.dmemSize  = sz;
        bus.dmemWdata = wd;
        @(posedge clk);
        #1;
        bus.dmemWen = 1'b0;
        bus.dmemRen = 1'b0;
        f     = mdl_fault(wen, ren, addr, sz);
        exp_e = 1'b0;
        if (model_ready && (wen || ren)) begin
            exp_e = f;
            if (ren) begin
                if (f) model_rdata = 32'h0;
                else   model_rdata = mdl_load(model_mem[addr / 4], addr, sz);
            end
            if (wen && !f) begin
                w = model_mem[addr / 4];
                n = size_bytes(sz);
                for (int k = 0; k < int'(n); k++) begin
                    w[8 * (int'(addr % 4) + k) +: 8] = wd[8 * k +: 8];
                end
                model_mem[addr / 4] = w;
            end
        end
        exp_d = model_rdata;
    endtask

    task automatic apply_reset(input int cycles);
        rst         = 1'b0;
        bus.dmemWen = 1'b0;
        bus.dmemRen = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        model_rdata = 32'h0;
        model_ready = 1'b0;
    endtask

    task automatic wait_ready(output int cnt, output logic err_seen);
        cnt      = 0;
        err_seen = 1'b0;
        while (!bus.dmemReady && cnt < 3 * DEPTH) begin
            @(posedge clk);
            #1;
            cnt++;
            if (bus.dmemErr) err_seen = 1'b1;
        end
        model_ready = 1'b1;
    endtask

    task automatic test_reset();
        int   cnt;
        logic es;
        apply_reset(3);
        n_vec++;
        if ({bus.dmemRdata, bus.dmemErr, bus.dmemReady} !== 34'h0) begin
            n_bad++;
            $display("FAIL reset_state: got rdata=%h err=%b ready=%b, expected 0/0/0",
                     bus.dmemRdata, bus.dmemErr, bus.dmemReady);
        end
        rst = 1'b1;
        wait_ready(cnt, es);
        n_vec++;
        if (cnt != DEPTH) begin
            n_bad++;
            $display("FAIL ready_latency: got %0d cycles, expected %0d", cnt, DEPTH);
        end
        n_vec++;
        if (es !== 1'b0) begin
            n_bad++;
            $display("FAIL init_err: got err pulse during init, expected none");
        end
    endtask

    task automatic test_init_clear();
        logic [31:0] d;
        logic        e;
        int          idx;
        for (int i = 0; i < 16; i++) begin
            idx = (i == 0) ? 0 : (i == 1) ? DEPTH - 1 : int'($urandom_range(2, DEPTH - 2));
            issue(1'b0, 1'b1, 32'(idx * 4), LS_W, 32'h0, d, e);
            n_vec++;
            if (bus.dmemRdata !== 32'h0 || bus.dmemErr !== 1'b0) begin
                n_bad++;
                $display("FAIL init_clear idx=%0d: got rdata=%h err=%b, expected 00000000/0",
                         idx, bus.dmemRdata, bus.dmemErr);
            end
        end
    endtask

    task automatic test_sign_ext();
        logic [31:0] d;
        logic        e;
        logic [31:0] a_t [9] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h10, 32'h11, 32'h12, 32'h10, 32'h12};
        logic [2:0]  s_t [9] = '{LS_B, LS_BU, LS_H, LS_HU, LS_B, LS_B, LS_B, LS_W, LS_HU};
        logic [31:0] x_t [9] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01, 32'h00000001,
                                 32'h0000007F, 32'hFFFFFFFF, 32'h80FF7F01, 32'h000080FF};
        issue(1'b1, 1'b0, 32'h10, LS_W, 32'h80FF7F01, d, e);
        for (int i = 0; i < 9; i++) begin
            issue(1'b0, 1'b1, a_t[i], s_t[i], 32'h0, d, e);
            n_vec++;
            if (bus.dmemRdata !== x_t[i] || bus.dmemErr !== 1'b0) begin
                n_bad++;
                $display("FAIL sign_ext #%0d @%h: got rdata=%h err=%b, expected %h/0",
                         i, a_t[i], bus.dmemRdata, bus.dmemErr, x_t[i]);
            end
        end
    endtask

    task automatic test_partial_store();
        logic [31:0] d;
        logic        e;
        issue(1'b1, 1'b0, 32'h20, LS_W, 32'h11223344, d, e);
        issue(1'b1, 1'b0, 32'h21, LS_B, 32'h123456AA, d, e);
        issue(1'b1, 1'b0, 32'h22, LS_H, 32'hFFFFBEEF, d, e);
        issue(1'b0, 1'b1, 32'h20, LS_W, 32'h0, d, e);
        n_vec++;
        if (bus.dmemRdata !== 32'hBEEFAA44 || bus.dmemErr !== 1'b0) begin
            n_bad++;
            $display("FAIL partial_store: got rdata=%h err=%b, expected BEEFAA44/0",
                     bus.dmemRdata, bus.dmemErr);
        end
    endtask

    task automatic test_faults();
        logic [31:0] d;
        logic        e;
        logic        w_t [12] = '{1, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 1};
        logic        r_t [12] = '{0, 1, 0, 1, 0, 1, 1, 1, 1, 0, 1, 0};
        logic [31:0] a_t [12] = '{32'h0, 32'h2, 32'h1, 32'(DEPTH * 4), 32'h0, 32'h0, 32'h0, 32'h0,
                                  32'h0, 32'h80000000, 32'h0, 32'h3};
        logic [2:0]  s_t [12] = '{LS_W, LS_W, LS_H, LS_B, LS_W, LS_W, LS_W, LS_W,
                                  3'b011, LS_W, LS_W, 3'b110};
        logic [31:0] wd_t [12] = '{32'h11223344, 32'h0, 32'hFFFF, 32'h0, 32'h0, 32'h0, 32'h99999999,
                                   32'h0, 32'h0, 32'h0, 32'h0, 32'h55};
        logic [31:0] xd_t [12] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h11223344, 32'h0,
                                   32'h11223344, 32'h0, 32'h0, 32'h11223344, 32'h0};
        logic        xe_t [12] = '{0, 1, 1, 1, 0, 0, 1, 0, 1, 1, 0, 1};
        for (int i = 0; i < 12; i++) begin
            issue(w_t[i], r_t[i], a_t[i], s_t[i], wd_t[i], d, e);
            n_vec++;
            if (bus.dmemErr !== xe_t[i] || (r_t[i] && bus.dmemRdata !== xd_t[i])) begin
                n_bad++;
                $display("FAIL faults #%0d @%h: got rdata=%h err=%b, expected rdata=%h err=%b",
                         i, a_t[i], bus.dmemRdata, bus.dmemErr, xd_t[i], xe_t[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic        e;
        issue(1'b1, 1'b0, 32'h40, LS_W, 32'h12345678, d, e);
        issue(1'b0, 1'b1, 32'h40, LS_W, 32'h0, d, e);
        n_vec++;
        if (bus.dmemRdata !== 32'h12345678) begin
            n_bad++;
            $display("FAIL b2b_store_load: got %h, expected 12345678", bus.dmemRdata);
        end
        issue(1'b1, 1'b0, 32'h44, LS_W, 32'h0BADF00D, d, e);
        issue(1'b0, 1'b0, 32'h0, LS_W, 32'h0, d, e);
        issue(1'b0, 1'b1, 32'h44, LS_W, 32'h0, d, e);
        issue(1'b1, 1'b0, 32'h44, LS_W, 32'hCAFEF00D, d, e);
        n_vec++;
        if (bus.dmemRdata !== 32'h0BADF00D) begin
            n_bad++;
            $display("FAIL b2b_load_store: got %h, expected 0BADF00D", bus.dmemRdata);
        end
        issue(1'b0, 1'b1, 32'h44, LS_W, 32'h0, d, e);
        n_vec++;
        if (bus.dmemRdata !== 32'hCAFEF00D) begin
            n_bad++;
            $display("FAIL b2b_new_value: got %h, expected CAFEF00D", bus.dmemRdata);
        end
    endtask

    task automatic test_hold();
        logic [31:0] d;
        logic        e;
        issue(1'b0, 1'b1, 32'h20, LS_W, 32'h0, d, e);
        issue(1'b0, 1'b0, 32'h20, LS_W, 32'h0, d, e);
        issue(1'b1, 1'b0, 32'h60, LS_W, 32'h77777777, d, e);
        issue(1'b0, 1'b0, 32'h60, LS_W, 32'h0, d, e);
        n_vec++;
        if (bus.dmemRdata !== 32'hBEEFAA44 || bus.dmemErr !== 1'b0) begin
            n_bad++;
            $display("FAIL hold: got rdata=%h err=%b, expected BEEFAA44/0", bus.dmemRdata, bus.dmemErr);
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic        e;
        logic [31:0] addr;
        logic [2:0]  sz;
        logic        wen;
        logic        ren;
        int unsigned r;
        int unsigned n;
        logic [2:0]  valid_t [5] = '{LS_B, LS_H, LS_W, LS_BU, LS_HU};
        logic [2:0]  bad_t [3]   = '{3'b011, 3'b110, 3'b111};
        for (int i = 0; i < 400; i++) begin
            r  = $urandom_range(0, 19);
            sz = (r < 18) ? valid_t[r % 5] : bad_t[r % 3];
            addr = 32'($urandom_range(0, 255));
            n = size_bytes(sz);
            if (n != 0 && $urandom_range(0, 9) < 7) addr = addr & ~(32'(n) - 32'd1);
            if ($urandom_range(0, 15) == 0) addr = addr | 32'(DEPTH * 4) | (32'($urandom) & 32'hFFFF0000);
            r   = $urandom_range(0, 19);
            wen = (r < 9) || (r == 19);
            ren = (r >= 9 && r < 17) || (r == 19);
            issue(wen, ren, addr, sz, $urandom, d, e);
            n_vec++;
            if (bus.dmemRdata !== d || bus.dmemErr !== e) begin
                n_bad++;
                $display("FAIL random #%0d w=%b r=%b @%h sz=%b: got rdata=%h err=%b, expected %h/%b",
                         i, wen, ren, addr, sz, bus.dmemRdata, bus.dmemErr, d, e);
            end
        end
    endtask

    task automatic test_reset_mid_ready();
        logic [31:0] d;
        logic        e;
        int          cnt;
        logic        es;
        issue(1'b1, 1'b0, 32'h50, LS_W, 32'h5A5A5A5A, d, e);
        issue(1'b0, 1'b1, 32'h50, LS_W, 32'h0, d, e);
        apply_reset(1);
        n_vec++;
        if ({bus.dmemRdata, bus.dmemErr, bus.dmemReady} !== 34'h0) begin
            n_bad++;
            $display("FAIL mid_ready_reset: got rdata=%h err=%b ready=%b, expected 0/0/0",
                     bus.dmemRdata, bus.dmemErr, bus.dmemReady);
        end
        rst = 1'b1;
        wait_ready(cnt, es);
        n_vec++;
        if (cnt != DEPTH || es !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_ready_reinit: got %0d cycles err=%b, expected %0d/0", cnt, es, DEPTH);
        end
        issue(1'b0, 1'b1, 32'h50, LS_W, 32'h0, d, e);
        n_vec++;
        if (bus.dmemRdata !== 32'h0) begin
            n_bad++;
            $display("FAIL mid_ready_cleared: got %h, expected 00000000", bus.dmemRdata);
        end
    endtask

    task automatic test_reset_mid_init();
        logic [31:0] d;
        logic        e;
        int          cnt;
        logic        es;
        apply_reset(2);
        rst = 1'b1;
        es  = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (bus.dmemErr) es = 1'b1;
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        wait_ready(cnt, e);
        n_vec++;
        if (cnt != DEPTH || es !== 1'b0 || e !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_init_reset: got %0d cycles err=%b/%b, expected %0d/0/0", cnt, es, e, DEPTH);
        end
        for (int i = 0; i < 64; i++) begin
            issue(1'b0, 1'b1, 32'(i * 4), LS_W, 32'h0, d, e);
            n_vec++;
            if (bus.dmemRdata !== 32'h0 || bus.dmemErr !== 1'b0) begin
                n_bad++;
                $display("FAIL mid_init_cleared idx=%0d: got %h err=%b, expected 00000000/0",
                         i, bus.dmemRdata, bus.dmemErr);
            end
        end
    endtask

    initial begin
        clk           = 1'b0;
        rst           = 1'b0;
        bus.dmemAddr  = 32'h0;
        bus.dmemWdata = 32'h0;
        bus.dmemSize  = LS_W;
        bus.dmemWen   = 1'b0;
        bus.dmemRen   = 1'b0;
        model_rdata   = 32'h0;
        model_ready   = 1'b0;
        test_reset();
        test_init_clear();
        test_sign_ext();
        test_partial_store();
        test_faults();
        test_back_to_back();
        test_hold();
        test_random();
        test_reset_mid_ready();
        test_reset_mid_init();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
